// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Parity support is enabled in the top level by defining PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int MAX_WIDTH = 256;

    function automatic int count_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame: cleared on load, stepped on each
// consumed bit, and saturating at the final position of the frame.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = count_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             is_first,
    output logic             is_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (advance && !is_last) begin
            count <= count + 1'b1;
        end
    end

    assign is_first = (count == '0);
    assign is_last  = (count == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer with valid/ready on both sides and first/last framing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = count_width(FRAME_LEN);

    piso_state_t          state_reg;
    logic [FRAME_LEN-1:0] shift_reg;
    logic [FRAME_LEN-1:0] load_word;
    logic [FRAME_LEN-1:0] shifted;
    logic                 shift_bit;
    logic                 load;
    logic                 advance;
    logic [CNT_W-1:0]     count;
    logic                 is_first;
    logic                 is_last;

    // The parity bit sits in the register so it leaves after the last data bit.
`ifdef PISO_PARITY_EN
    logic parity_bit;
    assign parity_bit = even_parity(MAX_WIDTH'(in_data));
    assign load_word  = (MSB_FIRST != 0) ? {in_data, parity_bit} : {parity_bit, in_data};
`else
    assign load_word  = in_data;
`endif

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_bit = shift_reg[FRAME_LEN-1];
            assign shifted   = {shift_reg[FRAME_LEN-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shift_bit = shift_reg[0];
            assign shifted   = {1'b0, shift_reg[FRAME_LEN-1:1]};
        end
    endgenerate

    assign busy      = (state_reg == SHIFT);
    assign out_valid = busy;
    assign out       = out_valid & shift_bit;
    assign out_first = out_valid & is_first;
    assign out_last  = out_valid & is_last;
    assign in_ready  = !rst && ((state_reg == IDLE) || (out_last && out_ready));
    assign load      = in_valid && in_ready;
    assign advance   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shift_reg <= load_word;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A load here can only coincide with the last-bit handshake.
                    if (load) begin
                        shift_reg <= load_word;
                    end else if (advance) begin
                        shift_reg <= shifted;
                        if (is_last) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .count    (count),
        .is_first (is_first),
        .is_last  (is_last)
    );

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(FRAME_LEN - 1));

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances,
// with frames expanded from the stimulus words (parity appended under PISO_PARITY_EN).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out, out_valid, out_ready, out_first, out_last, busy;
    logic [7:0] in_data;
    logic       in_valid_l, in_ready_l, out_l, out_valid_l, out_ready_l;
    logic       out_first_l, out_last_l, busy_l;
    logic [7:0] in_data_l;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [2:0] sb[$];
    logic [2:0] sb_l[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
        .out(out_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
        .out_first(out_first_l), .out_last(out_last_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit i of word w; position 8 is the even-parity bit.
    function automatic logic frame_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) valid_cycles++;
            else chk("msb_gated_out", {out, out_first, out_last}, 0);
            if (out_valid && out_ready) begin
                chk("msb_sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    logic [2:0] e;
                    e = sb.pop_front();
                    $display("msb bit out=%0b first=%0b last=%0b exp=%0b/%0b/%0b",
                             out, out_first, out_last, e[2], e[1], e[0]);
                    chk("msb_bit", out, e[2]);
                    chk("msb_first", out_first, e[1]);
                    chk("msb_last", out_last, e[0]);
                end
            end
            if (in_valid && in_ready)
                for (int i = 0; i < FL; i++) sb.push_back({frame_bit(in_data, i, 1'b1), i == 0, i == FL-1});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_l && out_ready_l) begin
                chk("lsb_sb_nonempty", sb_l.size() > 0, 1);
                if (sb_l.size() > 0) begin
                    logic [2:0] e;
                    e = sb_l.pop_front();
                    $display("lsb bit out=%0b first=%0b last=%0b exp=%0b/%0b/%0b",
                             out_l, out_first_l, out_last_l, e[2], e[1], e[0]);
                    chk("lsb_bit", out_l, e[2]);
                    chk("lsb_first", out_first_l, e[1]);
                    chk("lsb_last", out_last_l, e[0]);
                end
            end
            if (in_valid_l && in_ready_l)
                for (int i = 0; i < FL; i++) sb_l.push_back({frame_bit(in_data_l, i, 1'b0), i == 0, i == FL-1});
        end
    end

    // Presents a word and returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!out_valid && sb.size() == 0) break;
        end
        chk("drain_idle", out_valid, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid_l = 1'b0; in_data_l = '0; out_ready_l = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {out, out_valid, out_first, out_last, busy}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_lsb_outputs", {out_l, out_valid_l, in_ready_l, busy_l}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // Single frame, MSB first, with first-bit latency check
        valid_cycles = 0;
        send(8'hB1);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        chk("latency_first", out_first, 1);
        chk("mid_frame_in_ready", in_ready, 0);
        drain();
        chk("single_len", valid_cycles, FL);
        chk("single_end", {out_valid, busy, in_ready}, 3'b001);

        // Back-to-back, in_valid held across the frame boundary
        valid_cycles = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hB1;
        @(negedge clk);
        chk("b2b_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_data = 8'hAA;
        for (int i = 0; i < 2*FL; i++) begin
            @(negedge clk);
            chk("b2b_no_bubble", out_valid, 1);
            chk("b2b_in_ready", in_ready, (i % FL) == FL-1);
            if (i == FL-1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        drain();
        chk("b2b_len", valid_cycles, 2*FL);

        // Backpressure after the third bit
        valid_cycles = 0;
        send(8'hB1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {out, out_valid, out_first, out_last}, 4'b1100);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain();
        chk("bp_len", valid_cycles, FL + 3);

        // Reset in the middle of a frame, then a clean frame
        send(8'hB1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_outputs", {out_valid, out, busy, in_ready}, 0);
        sb.delete();
        @(negedge clk); #1 rst = 1'b0;
        valid_cycles = 0;
        send(8'hAA);
        drain();
        chk("after_rst_len", valid_cycles, FL);

        // Odd-weight word exercises a set parity bit
        send(8'h07);
        drain();

        // LSB-first instance
        @(posedge clk); #1;
        in_valid_l = 1'b1; in_data_l = 8'hB1;
        @(negedge clk);
        chk("lsb_accept", in_ready_l, 1);
        @(posedge clk); #1;
        in_valid_l = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!out_valid_l && sb_l.size() == 0) break;
        end
        chk("lsb_drain", {out_valid_l, busy_l}, 0);
        chk("lsb_sb_empty", sb_l.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the fixed 8-bit load/shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle.
- Emits with a serial valid/ready handshake, first/last framing flags and a configurable bit order.
- Sits between parallel datapath logic and a bit-serial link or transmitter.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  parallel word available.
- in_ready  out  1  serializer can accept a word this cycle.
- in_data  in  WIDTH  parallel word; captured when in_valid && in_ready.
- out  out  1  serial data bit.
- out_valid  out  1  out carries a valid bit.
- out_ready  in  1  downstream consumes the bit this cycle.
- out_first  out  1  current bit is first of frame.
- out_last  out  1  current bit is last of frame.
- busy  out  1  a frame is in progress (state == SHIFT).

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - state = IDLE, shift register = 0, bit count = 0.
  - out = 0, out_valid = 0, out_first = 0, out_last = 0, busy = 0.
  - in_ready is forced 0 while rst is high.
- FSM, two states:
  - IDLE: in_ready = 1. A handshake loads in_data into the shift register, clears the count and moves to SHIFT.
  - SHIFT: out_valid = 1.
- Latency: word accepted at edge N; its first bit is valid in the cycle after edge N.
- Advance: a bit is consumed only when out_valid && out_ready; then the register shifts (toward MSB if MSB_FIRST, else toward LSB) and the count increments.
  - With out_ready low, out, the count and all flags hold indefinitely.
- Framing and gating:
  - out_first = out_valid && count == 0.
  - out_last = out_valid && count == FRAME_LEN-1, where FRAME_LEN = WIDTH (or WIDTH+1 with parity).
  - out = 0 whenever out_valid = 0.
- Frame end: in SHIFT, in_ready = out_last && out_ready.
  - If the last bit is consumed and in_valid is high in the same cycle, the new word loads, state stays SHIFT and the count goes to 0. This gives a gapless back-to-back stream.
  - Otherwise the state returns to IDLE.
- In_valid while busy and not on the last-bit handshake is ignored; in_data is not sampled.
- Counter width is $clog2(FRAME_LEN+1). No wrap beyond FRAME_LEN-1.
- Reset mid-frame: the frame is abandoned immediately and outputs go to reset values asynchronously. No partial frame resumes.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the loaded word, captured at load) is appended after the data bits, so FRAME_LEN = WIDTH+1.
  - out_last marks the parity bit; out_first still marks the first data bit.
- Undefined: FRAME_LEN = WIDTH and no parity logic is present.

Decomposition:
- Package piso_pkg contains:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - function even_parity();
  - localparam helper for counter width.
- One natural sub-module: piso_bit_counter. It holds the load/advance/terminal-count logic and exposes count, is_first and is_last.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1, load 8'b10110001:
  - out = 1,0,1,1,0,0,0,1 over 8 consecutive cycles.
  - out_first on bit 1 only, out_last on bit 8 only.
  - Then out_valid=0, busy=0, in_ready=1.
- Back-to-back: in_valid held with 8'hB1 then 8'hAA:
  - 16 contiguous valid bits 10110001 10101010, no bubble.
  - in_ready high only in IDLE and on the last-bit cycle.
- Backpressure: out_ready low for 3 cycles after bit 3 of 8'hB1:
  - out holds 1 with out_valid=1 for those cycles.
  - Remaining bits 1,0,0,0,1 follow; total frame spans 11 cycles.
- Reset mid-frame: assert rst after 4 bits of 8'hB1:
  - out_valid, out, busy go 0 immediately.
  - After release, load 8'hAA -> full 1,0,1,0,1,0,1,0 with out_first on the first bit.
- MSB_FIRST=0, load 8'hB1 -> out = 1,0,0,0,1,1,0,1.
- PISO_PARITY_EN defined:
  - 8'hB1 -> 9 bits ending in parity 0, out_last on bit 9.
  - 8'h07 -> parity bit 1.
